alu_seq: RTL

Parametrised, registered successor to the team's 8-bit combinational ALU. Keeps the same 4-bit opcode map and carry/zero flags. Adds:
- generic operand width;
- valid/ready handshakes on input and output;
- variable shift/rotate amounts;
- an iterative multi-cycle divider with divide-by-zero reporting.

It sits between the instruction-issue logic and the register-file writeback, with one operation in flight at a time.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_div_iter.sv | 67 ++++++
 rtl/alu_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   op_e       - 4-bit opcode map shared with the legacy combinational ALU
//   state_e    - control FSM states
//   op_latency - accept-to-out_valid latency in cycles for an op
// Honours the ALU_SEQ_MULDIV_EN macro (multiply/divide datapaths present).
package alu_pkg;

`ifdef ALU_SEQ_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_MUL  = 4'd2,  OP_DIV  = 4'd3,
        OP_MOD  = 4'd4,  OP_AND  = 4'd5,  OP_OR   = 4'd6,  OP_NOT  = 4'd7,
        OP_NAND = 4'd8,  OP_NOR  = 4'd9,  OP_XOR  = 4'd10, OP_XNOR = 4'd11,
        OP_SHL  = 4'd12, OP_SHR  = 4'd13, OP_ROTL = 4'd14, OP_ROTR = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Only a real division (non-zero divisor) takes the iterative path.
    function automatic int unsigned op_latency(input op_e op, input logic b_zero,
                                               input int unsigned width);
        int unsigned lat;
        lat = 1;
        if (MULDIV_EN && (op == OP_DIV || op == OP_MOD) && !b_zero)
            lat = width + 1;
        return lat;
    endfunction

endpackage

// File: rtl/alu_div_iter.sv
// alu_div_iter: restoring divider, one quotient bit per clock.
//   clk, rst            - clock, async active-high reset
//   start               - load dividend/divisor and begin (divisor must be non-zero)
//   dividend, divisor   - unsigned operands
//   done                - one-cycle pulse once quotient/remainder are final
//   quotient, remainder - results, valid while done is high and held afterwards
module alu_div_iter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // Partial remainder shifted left with the next dividend bit; MSB of diff is the borrow.
    always_comb begin
        rem_sh = {remainder, quotient[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvsr};
    end

    // The quotient register doubles as the dividend shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvsr      <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quotient  <= dividend;
                remainder <= '0;
                dvsr      <= divisor;
                cnt       <= CW'(WIDTH);
                busy      <= 1'b1;
            end else if (busy) begin
                if (!diff[WIDTH]) begin
                    remainder <= diff[WIDTH-1:0];
                    quotient  <= {quotient[WIDTH-2:0], 1'b1};
                end else begin
                    remainder <= rem_sh[WIDTH-1:0];
                    quotient  <= {quotient[WIDTH-2:0], 1'b0};
                end
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes and an iterative divider.
//   clk, rst             - clock, async active-high reset
//   in_valid, in_ready   - request handshake (op, a, b captured on transfer)
//   op, a, b             - opcode (alu_pkg::op_e map) and unsigned operands
//   out_valid, out_ready - result handshake
//   result               - 2*WIDTH-bit result, zero-extended where narrower
//   flag_c, flag_z, flag_e - carry/borrow, zero, error
// Macro ALU_SEQ_MULDIV_EN enables Mul/Div/Mod; without it those ops report flag_e.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               flag_c,
    output logic               flag_z,
    output logic               flag_e
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned RW  = 2 * WIDTH;

    state_e           state;
    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] lo;
    logic [RW-1:0]    wide;
    logic             use_wide;
    logic [RW-1:0]    alu_res;
    logic             alu_c;
    logic             alu_e;
    logic             is_iter;

    // Single-cycle datapath, evaluated on the live inputs at the accept edge.
    always_comb begin
        lo       = '0;
        wide     = '0;
        use_wide = 1'b0;
        alu_c    = 1'b0;
        alu_e    = 1'b0;
        is_iter  = 1'b0;
        amt      = b[SHW-1:0];
        sum      = {1'b0, a} + {1'b0, b};
        case (op_e'(op))
            OP_ADD: begin
                wide     = RW'(sum);
                use_wide = 1'b1;
                alu_c    = sum[WIDTH];
            end
            OP_SUB: begin
                lo    = a - b;
                alu_c = (a < b);
            end
`ifdef ALU_SEQ_MULDIV_EN
            OP_MUL: begin
                wide     = RW'(a) * RW'(b);
                use_wide = 1'b1;
            end
            OP_DIV: begin
                if (b == '0) begin
                    lo    = '1;
                    alu_e = 1'b1;
                end else begin
                    is_iter = 1'b1;
                end
            end
            OP_MOD: begin
                if (b == '0) begin
                    lo    = a;
                    alu_e = 1'b1;
                end else begin
                    is_iter = 1'b1;
                end
            end
`else
            OP_MUL, OP_DIV, OP_MOD: alu_e = 1'b1;
`endif
            OP_AND:  lo = a & b;
            OP_OR:   lo = a | b;
            OP_NOT:  lo = ~a;
            OP_NAND: lo = ~(a & b);
            OP_NOR:  lo = ~(a | b);
            OP_XOR:  lo = a ^ b;
            OP_XNOR: lo = ~(a ^ b);
            OP_SHL:  lo = a << amt;
            OP_SHR:  lo = a >> amt;
            // A shift by the full width yields zero, so amount 0 returns a unchanged.
            OP_ROTL: lo = (a << amt) | (a >> (32'(WIDTH) - 32'(amt)));
            OP_ROTR: lo = (a >> amt) | (a << (32'(WIDTH) - 32'(amt)));
            default: lo = '0;
        endcase
        alu_res = use_wide ? wide : {{WIDTH{1'b0}}, lo};
    end

`ifdef ALU_SEQ_MULDIV_EN
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] div_lo;
    op_e              op_q;

    always_comb begin
        div_start = (state == ST_IDLE) && in_valid && is_iter;
        div_lo    = (op_q == OP_DIV) ? div_q : div_r;
    end

    alu_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (a),
        .divisor   (b),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );
`endif

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            flag_e    <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            op_q      <= OP_ADD;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
                        op_q     <= op_e'(op);
`endif
                        if (is_iter) begin
                            state <= ST_BUSY;
                        end else begin
                            result    <= alu_res;
                            flag_c    <= alu_c;
                            flag_z    <= (alu_res == '0);
                            flag_e    <= alu_e;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
`ifdef ALU_SEQ_MULDIV_EN
                    if (div_done) begin
                        result    <= {{WIDTH{1'b0}}, div_lo};
                        flag_c    <= 1'b0;
                        flag_z    <= (div_lo == '0);
                        flag_e    <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
`else
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
`endif
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
